// File: rtl/fsk_deframer.sv
// Recovers bytes from a serial FSK bit stream framed as header 8'hFE + 8 data bits, MSB first.
// data_out/data_valid update on the clk after the 8th data sample; no backpressure, every byte is presented once.
module fsk_deframer #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [CNT_W-1:0] PH_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PH_SAMPLE = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] PH_ONE    = CNT_W'(1);
  localparam logic [7:0]       HDR       = 8'hFE;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [7:0]       win_q, win_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic       s_bit;
  logic       edge_det;
  logic       tick;
  logic [7:0] win_shift;

  assign s_bit     = sync2_q;
  assign edge_det  = s_bit ^ prev_q;
  assign tick      = (phase_q == PH_SAMPLE);
  assign win_shift = {win_q[6:0], s_bit};

  always_comb begin
    sync1_d  = bit_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    state_d  = state_q;
    win_d    = win_q;
    bcnt_d   = bcnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;

    if (edge_det || phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_ONE;
    end

    if (tick) begin
      win_d = win_shift;
      case (state_q)
        HUNT: begin
          if (win_shift == HDR) begin
            state_d  = DATA;
            bcnt_d   = 3'd0;
            locked_d = 1'b1;
          end
        end
        DATA: begin
          // The window itself collects the byte: after 8 samples it holds them MSB first.
          if (bcnt_q == 3'd7) begin
            data_d  = win_shift;
            valid_d = 1'b1;
            state_d = CHECK;
            win_d   = 8'h00;
            bcnt_d  = 3'd0;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
        CHECK: begin
          if (bcnt_q == 3'd7) begin
            bcnt_d = 3'd0;
            if (win_shift == HDR) begin
              state_d = DATA;
            end else begin
              state_d  = HUNT;
              err_d    = 1'b1;
              locked_d = 1'b0;
            end
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      phase_q  <= '0;
      win_q    <= 8'h00;
      bcnt_q   <= 3'd0;
      state_q  <= HUNT;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      phase_q  <= phase_d;
      win_q    <= win_d;
      bcnt_q   <= bcnt_d;
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_fsk_deframer.sv
// Bench for fsk_deframer at CLK_DIV=8: frame table, reset/idle corner sequences, jittered random streams vs a bit-level parser.
module tb_fsk_deframer;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       sync_err;

  always #5 clk = ~clk;

  fsk_deframer #(.CLK_DIV(DIV), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] dat;
    logic       exp_lock;
    logic       exp_err;
    logic       exp_vld;
    logic [7:0] exp_dat;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  int         both_cnt = 0;
  int         spur_cnt = 0;
  int         cur_j = 0;
  bit         jit_en = 1'b0;
  logic       rst_edge = 1'b1;
  logic [7:0] last_do = 8'h00;
  logic [8:0] ev_q[$];
  bit         stream_q[$];
  logic [8:0] exp_q[$];

  // Event log: data bytes as {0,byte}, sync errors as 9'h100.
  always @(posedge clk) rst_edge <= !reset;

  always @(negedge clk) begin
    if (data_valid) ev_q.push_back({1'b0, data_out});
    if (sync_err) ev_q.push_back(9'h100);
    if (data_valid && sync_err) both_cnt++;
    if (!rst_edge && !data_valid && data_out !== last_do) spur_cnt++;
    last_do = data_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input string name, input logic [8:0] exp);
    if (ev_q.size() == 0) check(name, 32'hFFFF_FFFF, {23'd0, exp});
    else check(name, {23'd0, ev_q.pop_front()}, {23'd0, exp});
  endtask

  // Each bit edge sits at its nominal slot plus an offset of -1..+1 clk when jitter is enabled.
  task automatic send_bit(input logic b);
    int nj;
    int dur;
    bit_in = b;
    nj = jit_en ? int'($urandom_range(0, 2)) - 1 : 0;
    dur = DIV + nj - cur_j;
    cur_j = nj;
    repeat (dur) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [7:0] byte_end(input int q);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[7-k] = stream_q[q-7+k];
    return v;
  endfunction

  // Parse the sampled bit list: find a header ending at bit q, then data ends at q+8 and the next header slot at q+16.
  function automatic void build_expect();
    int n;
    int q;
    bit in_lock;
    n = stream_q.size();
    q = 7;
    exp_q.delete();
    while (q < n) begin
      if (byte_end(q) != 8'hFE) begin
        q++;
      end else begin
        in_lock = 1'b1;
        while (in_lock) begin
          if (q + 8 >= n) return;
          exp_q.push_back({1'b0, byte_end(q + 8)});
          if (q + 16 >= n) return;
          if (byte_end(q + 16) == 8'hFE) begin
            q += 16;
          end else begin
            exp_q.push_back(9'h100);
            q += 17;
            in_lock = 1'b0;
          end
        end
      end
    end
  endfunction

  vec_t vecs[8];

  initial begin
    int lock_hi;
    int nexp;
    logic [7:0] h;
    logic [7:0] d;

    vecs[0] = '{8'hFE, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[1] = '{8'hFE, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{8'hFE, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
    vecs[4] = '{8'hFE, 8'hFE, 1'b1, 1'b0, 1'b1, 8'hFE};
    vecs[5] = '{8'hFC, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{8'hFE, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C};
    vecs[7] = '{8'hFE, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};

    reset = 1'b0;
    bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) send_bit(1'b1);
    check("idle_locked", locked, 1'b0);
    check("idle_events", ev_q.size(), 0);
    ev_q.delete();

    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].hdr);
      check($sformatf("tbl%0d_locked", i), locked, vecs[i].exp_lock);
      send_byte(vecs[i].dat);
      nexp = int'(vecs[i].exp_err) + int'(vecs[i].exp_vld);
      check($sformatf("tbl%0d_nevents", i), ev_q.size(), nexp);
      if (vecs[i].exp_err) expect_ev($sformatf("tbl%0d_err", i), 9'h100);
      if (vecs[i].exp_vld) expect_ev($sformatf("tbl%0d_data", i), {1'b0, vecs[i].exp_dat});
      ev_q.delete();
    end

    // Stream stops: the pending header slot fails, then a long idle run must stay unlocked and silent.
    send_byte(8'hFF);
    check("drop_locked", locked, 1'b0);
    expect_ev("drop_err", 9'h100);
    ev_q.delete();
    lock_hi = 0;
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b1);
      if (locked) lock_hi++;
    end
    check("idle40_locked_cycles", lock_hi, 0);
    check("idle40_events", ev_q.size(), 0);

    // Reset during the fifth data bit of a locked frame.
    send_byte(8'hFE);
    send_byte(8'hA5);
    expect_ev("pre_rst_data", 9'h0A5);
    ev_q.delete();
    send_byte(8'hFE);
    d = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(d[i]);
    bit_in = d[3];
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_data_valid", data_valid, 1'b0);
    check("midrst_locked", locked, 1'b0);
    check("midrst_sync_err", sync_err, 1'b0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 2; i >= 0; i--) send_bit(d[i]);
    check("midrst_no_events", ev_q.size(), 0);
    send_byte(8'hFE);
    check("midrst_relock", locked, 1'b1);
    send_byte(8'hC3);
    check("midrst_nevents", ev_q.size(), 1);
    expect_ev("midrst_data", 9'h0C3);
    send_byte(8'hFF);
    ev_q.delete();

    // Random streams: idle, partial junk, frames (some with bad headers), idle tail; phase offset and edge jitter.
    for (int run = 0; run < 3; run++) begin
      do_reset();
      ev_q.delete();
      repeat ($urandom_range(0, DIV - 1)) @(posedge clk);
      #1;
      stream_q.delete();
      for (int i = 0; i < 10; i++) stream_q.push_back(1'b1);
      for (int i = 0; i < int'($urandom_range(0, 15)); i++) stream_q.push_back(1'($urandom));
      for (int f = 0; f < 6; f++) begin
        h = 8'hFE;
        if ($urandom_range(0, 4) == 0) begin
          h = 8'($urandom);
          if (h == 8'hFE) h = 8'hFC;
        end
        d = 8'($urandom);
        for (int i = 7; i >= 0; i--) stream_q.push_back(h[i]);
        for (int i = 7; i >= 0; i--) stream_q.push_back(d[i]);
      end
      for (int i = 0; i < 20; i++) stream_q.push_back(1'b1);
      build_expect();
      cur_j = 0;
      jit_en = 1'b1;
      foreach (stream_q[i]) send_bit(stream_q[i]);
      jit_en = 1'b0;
      cur_j = 0;
      repeat (2 * DIV) @(posedge clk);
      #1;
      check($sformatf("rnd%0d_nevents", run), ev_q.size(), exp_q.size());
      foreach (exp_q[k]) expect_ev($sformatf("rnd%0d_ev%0d", run, k), exp_q[k]);
      ev_q.delete();
    end

    check("valid_and_err_together", both_cnt, 0);
    check("data_out_changed_without_valid", spur_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
